l2_cache_request_arbiter: RTL

Front-of-pipeline scheduler for the L2 cache. It shares the single L2 tag-lookup slot among three sources: restarted miss-queue requests (fills and restarted flushes), a whole-cache flush walker, and NUM_REQUESTERS core request ports. It issues at most one registered request per cycle into the tag stage, which reads tags, dirty bits, valid bits and LRU state on the following cycle.

---
 rtl/l2_cache_request_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/l2_cache_request_arbiter.sv
// L2 front-of-pipeline scheduler: restart > flush walker > round-robin cores,
// issuing at most one registered request per cycle into the tag stage.
`ifndef L2_SETS
`define L2_SETS 8
`endif

typedef struct packed {
   logic [19:0]                   tag;
   logic [$clog2(`L2_SETS)-1:0]   set_idx;
   logic [5:0]                    offset;
} l2_addr_t;

typedef struct packed {
   logic [3:0] id;
   logic [2:0] op;
   l2_addr_t   address;
} l2req_packet_t;

typedef logic [63:0] cache_line_data_t;

module l2_cache_request_arbiter #(
   parameter int NUM_REQUESTERS = 4,
   parameter int NUM_SETS       = `L2_SETS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] core_request_valid,
   input  l2req_packet_t             core_request [NUM_REQUESTERS],
   output logic [NUM_REQUESTERS-1:0] core_request_ack,
   input  logic                      restart_valid,
   input  l2req_packet_t             restart_request,
   input  cache_line_data_t          restart_data,
   input  logic                      restart_is_fill,
   input  logic                      restart_is_flush,
   output logic                      restart_ack,
   input  logic                      downstream_stall,
   input  logic                      flush_all_start,
   output logic                      flush_all_busy,
   output logic                      flush_all_done,
   output logic                      l2a_request_valid,
   output l2req_packet_t             l2a_request,
   output cache_line_data_t          l2a_data_from_memory,
   output logic                      l2a_is_l2_fill,
   output logic                      l2a_is_restarted_flush,
   output logic                      l2a_is_set_flush
);
   localparam int RR_W  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
   localparam int IDX_W = $clog2(`L2_SETS);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} walk_state_t;

   walk_state_t      state_q, state_d;
   logic [SET_W-1:0] set_ctr_q, set_ctr_d;
   logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             req_valid_q, req_valid_d;
   l2req_packet_t    req_q, req_d;
   cache_line_data_t data_q, data_d;
   logic             is_fill_q, is_fill_d;
   logic             is_rflush_q, is_rflush_d;
   logic             is_set_flush_q, is_set_flush_d;

   logic             core_found;
   logic [RR_W-1:0]  core_idx;
   logic [RR_W-1:0]  cand;
   logic             walker_grant;
   logic             core_grant;
   l2req_packet_t    set_pkt;

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQUESTERS.
   always_comb begin
      core_found = 1'b0;
      core_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         cand = RR_W'((int'(rr_ptr_q) + i) % NUM_REQUESTERS);
         if (!core_found && core_request_valid[cand]) begin
            core_found = 1'b1;
            core_idx   = cand;
         end
      end
   end

   // Restarts bypass the stall: they release miss-queue resources.
   always_comb begin
      restart_ack      = restart_valid;
      walker_grant     = !restart_valid && !downstream_stall && (state_q == ST_WALK);
      core_grant       = !restart_valid && !downstream_stall && (state_q != ST_WALK) && core_found;
      core_request_ack = '0;
      if (core_grant) core_request_ack[core_idx] = 1'b1;
      rr_ptr_d = rr_ptr_q;
      if (core_grant) rr_ptr_d = (core_idx == RR_W'(NUM_REQUESTERS - 1)) ? '0 : core_idx + 1'b1;
   end

   always_comb begin
      state_d        = state_q;
      set_ctr_d      = set_ctr_q;
      flush_all_done = 1'b0;
      flush_all_busy = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE: if (flush_all_start) begin
            state_d   = ST_WALK;
            set_ctr_d = '0;
         end
         ST_WALK: if (walker_grant) begin
            if (set_ctr_q == LAST_SET) state_d = ST_DONE;
            else                       set_ctr_d = set_ctr_q + 1'b1;
         end
         ST_DONE: begin
            flush_all_done = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      set_pkt                  = '0;
      set_pkt.address.set_idx  = IDX_W'(set_ctr_q);
      req_valid_d              = restart_valid | walker_grant | core_grant;
      req_d                    = req_q;
      data_d                   = data_q;
      is_fill_d                = restart_valid & restart_is_fill;
      is_rflush_d              = restart_valid & restart_is_flush;
      is_set_flush_d           = walker_grant;
      if (restart_valid) begin
         req_d  = restart_request;
         data_d = restart_data;
      end else if (walker_grant) begin
         req_d = set_pkt;
      end else if (core_grant) begin
         req_d = core_request[core_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         set_ctr_q      <= '0;
         rr_ptr_q       <= '0;
         req_valid_q    <= 1'b0;
         req_q          <= '0;
         data_q         <= '0;
         is_fill_q      <= 1'b0;
         is_rflush_q    <= 1'b0;
         is_set_flush_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         set_ctr_q      <= set_ctr_d;
         rr_ptr_q       <= rr_ptr_d;
         req_valid_q    <= req_valid_d;
         req_q          <= req_d;
         data_q         <= data_d;
         is_fill_q      <= is_fill_d;
         is_rflush_q    <= is_rflush_d;
         is_set_flush_q <= is_set_flush_d;
      end
   end

   assign l2a_request_valid      = req_valid_q;
   assign l2a_request            = req_q;
   assign l2a_data_from_memory   = data_q;
   assign l2a_is_l2_fill         = is_fill_q;
   assign l2a_is_restarted_flush = is_rflush_q;
   assign l2a_is_set_flush       = is_set_flush_q;

endmodule
